// File: rtl/rf_wb_scoreboard_pkg.sv
// ----------------------------------------------------------------------------
// rf_wb_scoreboard_pkg
//   Shared register-file parameters and types for the writeback scheduler.
//   NB_REGS : width of a register address (32 architectural registers)
//   XLEN    : integer register width
//   wb_req_t: one writeback request / registered write-port beat
// ----------------------------------------------------------------------------
package rf_wb_scoreboard_pkg;

    localparam int NB_REGS      = 5;
    localparam int XLEN         = 32;
    localparam int NUM_REGS     = 1 << NB_REGS;
    localparam int STARVE_CNT_W = 4;

    // Grant vector bit positions
    localparam int GNT_ALU = 0;
    localparam int GNT_LSU = 1;

    typedef struct packed {
        logic               valid;
        logic [NB_REGS-1:0] adr;
        logic [XLEN-1:0]    data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_arb.sv
// ----------------------------------------------------------------------------
// rf_wb_arb
//   Two-source writeback arbiter. The LSU source (req1) wins by default; the
//   ALU source (req0) wins when alone or once it has lost STARVE_LIMIT
//   consecutive arbitrations.
//   Ports:
//     clk, reset_n       clock, asynchronous active-low reset
//     req0_valid_i       ALU writeback request
//     req1_valid_i       LSU writeback request
//     gnt_o              one-hot grant (GNT_ALU / GNT_LSU), combinational
//     starve_cnt_o       consecutive ALU losses
// ----------------------------------------------------------------------------
module rf_wb_arb
    import rf_wb_scoreboard_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req0_valid_i,
    input  logic                    req1_valid_i,
    output logic [1:0]              gnt_o,
    output logic [STARVE_CNT_W-1:0] starve_cnt_o
);

    logic [STARVE_CNT_W-1:0] starve_cnt_q;
    logic [STARVE_CNT_W-1:0] starve_cnt_d;
    logic                    alu_turn;

    assign alu_turn = (starve_cnt_q == STARVE_CNT_W'(STARVE_LIMIT));

    always_comb begin
        gnt_o        = '0;
        starve_cnt_d = starve_cnt_q;

        if (req0_valid_i && (!req1_valid_i || alu_turn)) begin
            gnt_o[GNT_ALU] = 1'b1;
        end else if (req1_valid_i) begin
            gnt_o[GNT_LSU] = 1'b1;
        end

        // The count only runs while the ALU is waiting and losing; any
        // cycle where it is idle or served starts it over.
        if (!req0_valid_i || gnt_o[GNT_ALU]) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != '1) begin
            starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign starve_cnt_o = starve_cnt_q;

endmodule

// File: rtl/rf_wb_scoreboard.sv
// ----------------------------------------------------------------------------
// rf_wb_scoreboard
//   Busy-bit scoreboard and write-port scheduler for the 32-entry integer
//   register file. Stalls issue on RAW/WAW hazards, arbitrates the ALU and
//   LSU writeback paths onto the single write port through a registered
//   output stage, and clears busy bits as writes commit.
//   Ports:
//     clk, reset_n                 clock, asynchronous active-low reset
//     issue_*                      decode/issue request and ready
//     wb0_* / wb1_*                ALU / LSU writeback requests and grants
//     write_valid/adr/data_o       register-file write port
//     busy_o                       pending-write mask
//     spurious_o                   commit to a non-busy register (not x0)
// ----------------------------------------------------------------------------
module rf_wb_scoreboard
    import rf_wb_scoreboard_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                issue_valid_i,
    input  logic [NB_REGS-1:0]  issue_rs1_adr_i,
    input  logic [NB_REGS-1:0]  issue_rs2_adr_i,
    input  logic                issue_rd_we_i,
    input  logic [NB_REGS-1:0]  issue_rd_adr_i,
    output logic                issue_ready_o,
    input  logic                wb0_valid_i,
    input  logic [NB_REGS-1:0]  wb0_adr_i,
    input  logic [XLEN-1:0]     wb0_data_i,
    output logic                wb0_ready_o,
    input  logic                wb1_valid_i,
    input  logic [NB_REGS-1:0]  wb1_adr_i,
    input  logic [XLEN-1:0]     wb1_data_i,
    output logic                wb1_ready_o,
    output logic                write_valid_o,
    output logic [NB_REGS-1:0]  write_adr_o,
    output logic [XLEN-1:0]     write_data_o,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                spurious_o
);

    logic [NUM_REGS-1:0]     busy_q;
    logic [NUM_REGS-1:0]     busy_d;
    wb_req_t                 out_q;
    wb_req_t                 out_d;
    wb_req_t                 wb0_req;
    wb_req_t                 wb1_req;
    logic [1:0]              gnt;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic                    issue_set;
    logic                    commit;

    assign wb0_req = '{valid: wb0_valid_i, adr: wb0_adr_i, data: wb0_data_i};
    assign wb1_req = '{valid: wb1_valid_i, adr: wb1_adr_i, data: wb1_data_i};

    rf_wb_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk          (clk),
        .reset_n      (reset_n),
        .req0_valid_i (wb0_valid_i),
        .req1_valid_i (wb1_valid_i),
        .gnt_o        (gnt),
        .starve_cnt_o (starve_cnt)
    );

    assign wb0_ready_o = gnt[GNT_ALU];
    assign wb1_ready_o = gnt[GNT_LSU];

    // Hazard check against the registered busy mask only: a write committing
    // this cycle is not bypassed, so a dependent issue waits one more cycle.
    assign issue_ready_o = ~(busy_q[issue_rs1_adr_i] | busy_q[issue_rs2_adr_i] |
                             (issue_rd_we_i & busy_q[issue_rd_adr_i]));

    assign issue_set = issue_valid_i & issue_ready_o & issue_rd_we_i &
                       (issue_rd_adr_i != '0);
    assign commit    = out_q.valid & (out_q.adr != '0);

    // x0 never becomes busy.
    assign busy_d[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
            logic set_bit;
            logic clr_bit;
            assign set_bit = issue_set & (issue_rd_adr_i == NB_REGS'(gi));
            assign clr_bit = commit & (out_q.adr == NB_REGS'(gi));
            // Set dominates a same-edge clear of the same register.
            assign busy_d[gi] = set_bit | (busy_q[gi] & ~clr_bit);
        end
    endgenerate

    always_comb begin
        out_d       = out_q;
        out_d.valid = 1'b0;
        if (gnt[GNT_ALU]) begin
            out_d = wb0_req;
        end else if (gnt[GNT_LSU]) begin
            out_d = wb1_req;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            out_q  <= '0;
        end else begin
            busy_q <= busy_d;
            out_q  <= out_d;
        end
    end

    assign write_valid_o = commit;
    assign write_adr_o   = out_q.adr;
    assign write_data_o  = out_q.data;
    assign busy_o        = busy_q;
    assign spurious_o    = commit & ~busy_q[out_q.adr];

    // The ALU is always served once its loss count reaches the limit, so the
    // counter never climbs past it.
    a_starve_bound: assert property (@(posedge clk) disable iff (!reset_n)
                                     starve_cnt <= STARVE_CNT_W'(STARVE_LIMIT));

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
module tb_rf_wb_scoreboard;
    import rf_wb_scoreboard_pkg::*;

    localparam int LIMIT = 3;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               issue_valid_i;
    logic [4:0]         issue_rs1_adr_i, issue_rs2_adr_i, issue_rd_adr_i;
    logic               issue_rd_we_i;
    logic               issue_ready_o;
    logic               wb0_valid_i, wb1_valid_i;
    logic [4:0]         wb0_adr_i, wb1_adr_i;
    logic [31:0]        wb0_data_i, wb1_data_i;
    logic               wb0_ready_o, wb1_ready_o;
    logic               write_valid_o;
    logic [4:0]         write_adr_o;
    logic [31:0]        write_data_o;
    logic [31:0]        busy_o;
    logic               spurious_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: set of pending registers, the beat waiting in the
    // write stage, and how many times in a row the ALU has been passed over.
    bit          m_busy [32];
    bit          m_ov;
    logic [4:0]  m_oadr;
    logic [31:0] m_odata;
    int          m_lost;
    bit          e_g0_last, e_g1_last;

    // DUT outputs captured at the last negedge
    logic        s_ready, s_g0, s_g1, s_wv, s_spur;
    logic [4:0]  s_adr;
    logic [31:0] s_data, s_busy;

    rf_wb_scoreboard #(.STARVE_LIMIT(LIMIT)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .issue_valid_i   (issue_valid_i),
        .issue_rs1_adr_i (issue_rs1_adr_i),
        .issue_rs2_adr_i (issue_rs2_adr_i),
        .issue_rd_we_i   (issue_rd_we_i),
        .issue_rd_adr_i  (issue_rd_adr_i),
        .issue_ready_o   (issue_ready_o),
        .wb0_valid_i     (wb0_valid_i),
        .wb0_adr_i       (wb0_adr_i),
        .wb0_data_i      (wb0_data_i),
        .wb0_ready_o     (wb0_ready_o),
        .wb1_valid_i     (wb1_valid_i),
        .wb1_adr_i       (wb1_adr_i),
        .wb1_data_i      (wb1_data_i),
        .wb1_ready_o     (wb1_ready_o),
        .write_valid_o   (write_valid_o),
        .write_adr_o     (write_adr_o),
        .write_data_o    (write_data_o),
        .busy_o          (busy_o),
        .spurious_o      (spurious_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        issue_valid_i   = 1'b0;
        issue_rs1_adr_i = '0;
        issue_rs2_adr_i = '0;
        issue_rd_we_i   = 1'b0;
        issue_rd_adr_i  = '0;
        wb0_valid_i     = 1'b0;
        wb0_adr_i       = '0;
        wb0_data_i      = '0;
        wb1_valid_i     = 1'b0;
        wb1_adr_i       = '0;
        wb1_data_i      = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_ov      = 1'b0;
        m_oadr    = '0;
        m_odata   = '0;
        m_lost    = 0;
        e_g0_last = 1'b0;
        e_g1_last = 1'b0;
    endtask

    // Called at the negedge: compare DUT against the model, then advance
    // the model to what it must hold after the coming posedge.
    task automatic model_check_update();
        logic [31:0] exp_busy;
        bit e_ready, e_g0, e_g1, e_wv, e_spur;
        for (int i = 0; i < 32; i++) exp_busy[i] = m_busy[i];
        e_ready = !(m_busy[issue_rs1_adr_i] || m_busy[issue_rs2_adr_i] ||
                    (issue_rd_we_i && m_busy[issue_rd_adr_i]));
        e_g0    = wb0_valid_i && (!wb1_valid_i || m_lost >= LIMIT);
        e_g1    = wb1_valid_i && !e_g0;
        e_wv    = m_ov && (m_oadr != 0);
        e_spur  = e_wv && !m_busy[m_oadr];

        s_ready = issue_ready_o; s_g0 = wb0_ready_o; s_g1 = wb1_ready_o;
        s_wv = write_valid_o; s_spur = spurious_o; s_adr = write_adr_o;
        s_data = write_data_o; s_busy = busy_o;

        check_eq("busy_o", 64'(s_busy), 64'(exp_busy));
        check_eq("issue_ready", 64'(s_ready), 64'(e_ready));
        check_eq("wb0_ready", 64'(s_g0), 64'(e_g0));
        check_eq("wb1_ready", 64'(s_g1), 64'(e_g1));
        check_eq("write_valid", 64'(s_wv), 64'(e_wv));
        check_eq("spurious", 64'(s_spur), 64'(e_spur));
        if (e_wv) begin
            check_eq("write_adr", 64'(s_adr), 64'(m_oadr));
            check_eq("write_data", 64'(s_data), 64'(m_odata));
            $display("TXN commit adr=%0d data=0x%08h spurious=%0d", m_oadr, m_odata, e_spur);
        end

        if (e_wv) m_busy[m_oadr] = 1'b0;
        if (issue_valid_i && e_ready && issue_rd_we_i && issue_rd_adr_i != 0)
            m_busy[issue_rd_adr_i] = 1'b1;
        m_ov = e_g0 || e_g1;
        if (e_g0) begin
            m_oadr = wb0_adr_i; m_odata = wb0_data_i;
        end else if (e_g1) begin
            m_oadr = wb1_adr_i; m_odata = wb1_data_i;
        end
        if (!wb0_valid_i || e_g0) m_lost = 0;
        else if (m_lost < 15) m_lost++;
        e_g0_last = e_g0;
        e_g1_last = e_g1;
    endtask

    task automatic step();
        @(negedge clk);
        model_check_update();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] pick_adr();
        logic [4:0] r;
        r = 5'($urandom_range(0, 31));
        for (int k = 0; k < 6; k++) begin
            if (m_busy[r]) return r;
            r = 5'($urandom_range(0, 31));
        end
        return r;
    endfunction

    initial begin
        idle_inputs();
        model_reset();
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", 64'(busy_o), 64'h0);
        check_eq("rst_ready", 64'(issue_ready_o), 64'h1);
        check_eq("rst_wb0_ready", 64'(wb0_ready_o), 64'h0);
        check_eq("rst_wb1_ready", 64'(wb1_ready_o), 64'h0);
        check_eq("rst_write_valid", 64'(write_valid_o), 64'h0);
        check_eq("rst_write_adr", 64'(write_adr_o), 64'h0);
        check_eq("rst_write_data", 64'(write_data_o), 64'h0);
        check_eq("rst_spurious", 64'(spurious_o), 64'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step();

        // Issue rd=5, then ALU writeback to 5
        issue_valid_i = 1'b1; issue_rd_we_i = 1'b1; issue_rd_adr_i = 5'd5;
        step();
        $display("TXN issue rd=5");
        idle_inputs();
        wb0_valid_i = 1'b1; wb0_adr_i = 5'd5; wb0_data_i = 32'hDEADBEEF;
        step();
        check_eq("t1_busy5_set", 64'(s_busy[5]), 64'h1);
        check_eq("t1_wb0_grant", 64'(s_g0), 64'h1);
        idle_inputs();
        step();
        check_eq("t1_write_valid", 64'(s_wv), 64'h1);
        check_eq("t1_write_adr", 64'(s_adr), 64'd5);
        check_eq("t1_write_data", 64'(s_data), 64'hDEADBEEF);
        step();
        check_eq("t1_busy5_clr", 64'(s_busy[5]), 64'h0);

        // RAW stall on x7 while the LSU write is in flight
        issue_valid_i = 1'b1; issue_rd_we_i = 1'b1; issue_rd_adr_i = 5'd7;
        step();
        idle_inputs();
        issue_valid_i = 1'b1; issue_rs1_adr_i = 5'd7;
        wb1_valid_i = 1'b1; wb1_adr_i = 5'd7; wb1_data_i = 32'h0000_7777;
        step();
        check_eq("t2_ready_grant", 64'(s_ready), 64'h0);
        check_eq("t2_wb1_grant", 64'(s_g1), 64'h1);
        wb1_valid_i = 1'b0;
        step();
        check_eq("t2_ready_commit", 64'(s_ready), 64'h0);
        check_eq("t2_commit", 64'(s_wv), 64'h1);
        step();
        check_eq("t2_ready_after", 64'(s_ready), 64'h1);
        idle_inputs();
        step();

        // Continuous contention: LSU,LSU,LSU,ALU repeating
        wb0_valid_i = 1'b1; wb0_adr_i = 5'd0; wb0_data_i = 32'h1;
        wb1_valid_i = 1'b1; wb1_adr_i = 5'd0; wb1_data_i = 32'h2;
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq($sformatf("t3_pattern_lsu%0d", i), 64'(s_g1), 64'((i % 4) != 3));
            check_eq($sformatf("t3_pattern_alu%0d", i), 64'(s_g0), 64'((i % 4) == 3));
            $display("TXN contend cycle=%0d grant=%s", i, s_g0 ? "wb0" : "wb1");
        end
        idle_inputs();
        step();

        // Write to x0 is consumed silently
        wb0_valid_i = 1'b1; wb0_adr_i = 5'd0; wb0_data_i = 32'h1234;
        step();
        check_eq("t4_wb0_ready", 64'(s_g0), 64'h1);
        idle_inputs();
        step();
        check_eq("t4_no_write", 64'(s_wv), 64'h0);
        check_eq("t4_no_spurious", 64'(s_spur), 64'h0);

        // Write to a non-busy register flags spurious
        wb1_valid_i = 1'b1; wb1_adr_i = 5'd9; wb1_data_i = 32'h9999_0009;
        step();
        check_eq("t5_busy9_clear", 64'(s_busy[9]), 64'h0);
        idle_inputs();
        step();
        check_eq("t5_write", 64'(s_wv), 64'h1);
        check_eq("t5_spurious", 64'(s_spur), 64'h1);
        step();
        check_eq("t5_spurious_drop", 64'(s_spur), 64'h0);

        // Reset with busy[3] set and a grant sitting in the write stage
        issue_valid_i = 1'b1; issue_rd_we_i = 1'b1; issue_rd_adr_i = 5'd3;
        step();
        idle_inputs();
        wb1_valid_i = 1'b1; wb1_adr_i = 5'd3; wb1_data_i = 32'hCAFE_0003;
        step();
        idle_inputs();
        issue_rs1_adr_i = 5'd3;
        check_eq("t6_pre_busy3", 64'(busy_o[3]), 64'h1);
        check_eq("t6_pre_valid", 64'(write_valid_o), 64'h1);
        reset_n = 1'b0;
        #1;
        check_eq("t6_busy", 64'(busy_o), 64'h0);
        check_eq("t6_write_valid", 64'(write_valid_o), 64'h0);
        check_eq("t6_ready", 64'(issue_ready_o), 64'h1);
        $display("TXN async reset");
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle_inputs();
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            issue_valid_i   = ($urandom_range(0, 2) == 0);
            issue_rs1_adr_i = 5'($urandom_range(0, 31));
            issue_rs2_adr_i = 5'($urandom_range(0, 31));
            issue_rd_we_i   = ($urandom_range(0, 3) != 0);
            issue_rd_adr_i  = 5'($urandom_range(0, 31));
            if (wb0_valid_i && e_g0_last) wb0_valid_i = 1'b0;
            if (wb1_valid_i && e_g1_last) wb1_valid_i = 1'b0;
            if (!wb0_valid_i && $urandom_range(0, 2) != 0) begin
                wb0_valid_i = 1'b1; wb0_adr_i = pick_adr(); wb0_data_i = $urandom;
            end
            if (!wb1_valid_i && $urandom_range(0, 2) != 0) begin
                wb1_valid_i = 1'b1; wb1_adr_i = pick_adr(); wb1_data_i = $urandom;
            end
            step();
        end
        idle_inputs();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
